// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard bubble insertion.
// Latency: one cycle from the ID-side inputs to the EX-side outputs.
// Backpressure: o_Stall holds the PC and IF/ID for one cycle on a load-use hazard; i_Enable=0 freezes all state.
//
// Ports:
//   i_clk, i_reset            clock (rising edge), synchronous active-high reset
//   i_Enable, i_Flush         debug step enable, squash of the instruction entering EX
//   i_Valid + decoder bundle  controls, operands and register fields of the ID instruction
//   o_*                       registered copy of the above as seen by EX
//   o_Stall                   combinational load-use stall toward PC and IF/ID
//   o_StallCount              saturating count of bubbles inserted by load-use stalls
//
// Build option: define LOAD_USE_STALL_EN to build the hazard detector and stall counter.
// Without it, o_Stall and o_StallCount are tied to 0 and software must fill load delay slots.
module id_ex_stage #(
    parameter int NBITS   = 32,
    parameter int RNBITS  = 5,
    parameter int CNTBITS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_Enable,
    input  logic               i_Flush,
    input  logic               i_Valid,
    input  logic               i_RegDst,
    input  logic               i_Jump,
    input  logic               i_Branch,
    input  logic               i_MemRead,
    input  logic               i_MemToReg,
    input  logic               i_MemWrite,
    input  logic               i_ALUSrc,
    input  logic               i_RegWrite,
    input  logic [1:0]         i_ALUOp,
    input  logic [NBITS-1:0]   i_PC4,
    input  logic [NBITS-1:0]   i_ReadData1,
    input  logic [NBITS-1:0]   i_ReadData2,
    input  logic [NBITS-1:0]   i_Imm,
    input  logic [RNBITS-1:0]  i_Rs,
    input  logic [RNBITS-1:0]  i_Rt,
    input  logic [RNBITS-1:0]  i_Rd,
    input  logic [5:0]         i_Funct,
    output logic               o_Valid,
    output logic               o_RegDst,
    output logic               o_Jump,
    output logic               o_Branch,
    output logic               o_MemRead,
    output logic               o_MemToReg,
    output logic               o_MemWrite,
    output logic               o_ALUSrc,
    output logic               o_RegWrite,
    output logic [1:0]         o_ALUOp,
    output logic [NBITS-1:0]   o_PC4,
    output logic [NBITS-1:0]   o_ReadData1,
    output logic [NBITS-1:0]   o_ReadData2,
    output logic [NBITS-1:0]   o_Imm,
    output logic [RNBITS-1:0]  o_Rs,
    output logic [RNBITS-1:0]  o_Rt,
    output logic [RNBITS-1:0]  o_Rd,
    output logic [5:0]         o_Funct,
    output logic               o_Stall,
    output logic [CNTBITS-1:0] o_StallCount
);

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [NBITS-1:0]  pc4;
        logic [NBITS-1:0]  rd1;
        logic [NBITS-1:0]  rd2;
        logic [NBITS-1:0]  imm;
        logic [RNBITS-1:0] rs;
        logic [RNBITS-1:0] rt;
        logic [RNBITS-1:0] rd;
        logic [5:0]        funct;
    } data_t;

    ctrl_t ctrl_in, ctrl_q, ctrl_d;
    data_t data_in, data_q, data_d;
    logic  valid_q, valid_d;
    logic  hz;

    assign ctrl_in = '{
        reg_dst:    i_RegDst,
        jump:       i_Jump,
        branch:     i_Branch,
        mem_read:   i_MemRead,
        mem_to_reg: i_MemToReg,
        mem_write:  i_MemWrite,
        alu_src:    i_ALUSrc,
        reg_write:  i_RegWrite,
        alu_op:     i_ALUOp
    };

    assign data_in = '{
        pc4:   i_PC4,
        rd1:   i_ReadData1,
        rd2:   i_ReadData2,
        imm:   i_Imm,
        rs:    i_Rs,
        rt:    i_Rt,
        rd:    i_Rd,
        funct: i_Funct
    };

`ifdef LOAD_USE_STALL_EN
    logic               uses_rt;
    logic [CNTBITS-1:0] cnt_q, cnt_d;

    // Rt is a true source only for R-type, stores and branches; for loads/ADDI it is the destination.
    assign uses_rt = i_RegDst | i_MemWrite | i_Branch;

    // A load in EX whose destination (Rt, never $zero) is read by the real instruction in ID.
    assign hz = valid_q & ctrl_q.mem_read & i_Valid & (data_q.rt != '0) &
                ((data_q.rt == i_Rs) | (uses_rt & (data_q.rt == i_Rt)));

    // Deliberately not gated by i_Enable: the upstream stages are frozen by it anyway.
    assign o_Stall = hz & ~i_Flush & ~i_reset;

    // Counts only bubbles actually loaded because of the hazard; a flush takes precedence.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Enable && !i_Flush && hz && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTBITS'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_StallCount = cnt_q;
`else
    assign hz           = 1'b0;
    assign o_Stall      = 1'b0;
    assign o_StallCount = '0;
`endif

    // Priority below reset: frozen when disabled, then flush/hazard bubble, then capture.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (i_Enable) begin
            if (i_Flush || hz) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                data_d  = '0;
            end else begin
                // Controls pass through even for i_Valid=0; EX qualifies on o_Valid.
                valid_d = i_Valid;
                ctrl_d  = ctrl_in;
                data_d  = data_in;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign o_Valid     = valid_q;
    assign o_RegDst    = ctrl_q.reg_dst;
    assign o_Jump      = ctrl_q.jump;
    assign o_Branch    = ctrl_q.branch;
    assign o_MemRead   = ctrl_q.mem_read;
    assign o_MemToReg  = ctrl_q.mem_to_reg;
    assign o_MemWrite  = ctrl_q.mem_write;
    assign o_ALUSrc    = ctrl_q.alu_src;
    assign o_RegWrite  = ctrl_q.reg_write;
    assign o_ALUOp     = ctrl_q.alu_op;
    assign o_PC4       = data_q.pc4;
    assign o_ReadData1 = data_q.rd1;
    assign o_ReadData2 = data_q.rd2;
    assign o_Imm       = data_q.imm;
    assign o_Rs        = data_q.rs;
    assign o_Rt        = data_q.rt;
    assign o_Rd        = data_q.rd;
    assign o_Funct     = data_q.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed instruction sequences, an instruction-level model and literal spot checks.
// Latency: expects ID inputs to appear on EX outputs one edge later.
// Backpressure: exercises load-use stalls, flush priority, enable freeze and reset mid-stall.
module tb_id_ex_stage;

`ifdef LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        regdst;
        logic        jump;
        logic        branch;
        logic        memread;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regwrite;
        logic [1:0]  aluop;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } instr_t;

    logic   clk;
    logic   rst;
    logic   en;
    logic   flush;
    instr_t id;

    logic        o_Valid, o_RegDst, o_Jump, o_Branch, o_MemRead, o_MemToReg;
    logic        o_MemWrite, o_ALUSrc, o_RegWrite, o_Stall;
    logic [1:0]  o_ALUOp;
    logic [31:0] o_PC4, o_ReadData1, o_ReadData2, o_Imm;
    logic [4:0]  o_Rs, o_Rt, o_Rd;
    logic [5:0]  o_Funct;
    logic [15:0] o_StallCount;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model state: the instruction EX should hold and the expected stall count.
    instr_t      ex_m;
    logic [15:0] cnt_m;

    id_ex_stage dut (
        .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Flush(flush), .i_Valid(id.valid),
        .i_RegDst(id.regdst), .i_Jump(id.jump), .i_Branch(id.branch), .i_MemRead(id.memread),
        .i_MemToReg(id.memtoreg), .i_MemWrite(id.memwrite), .i_ALUSrc(id.alusrc),
        .i_RegWrite(id.regwrite), .i_ALUOp(id.aluop), .i_PC4(id.pc4), .i_ReadData1(id.rd1),
        .i_ReadData2(id.rd2), .i_Imm(id.imm), .i_Rs(id.rs), .i_Rt(id.rt), .i_Rd(id.rd),
        .i_Funct(id.funct),
        .o_Valid(o_Valid), .o_RegDst(o_RegDst), .o_Jump(o_Jump), .o_Branch(o_Branch),
        .o_MemRead(o_MemRead), .o_MemToReg(o_MemToReg), .o_MemWrite(o_MemWrite),
        .o_ALUSrc(o_ALUSrc), .o_RegWrite(o_RegWrite), .o_ALUOp(o_ALUOp), .o_PC4(o_PC4),
        .o_ReadData1(o_ReadData1), .o_ReadData2(o_ReadData2), .o_Imm(o_Imm), .o_Rs(o_Rs),
        .o_Rt(o_Rt), .o_Rd(o_Rd), .o_Funct(o_Funct), .o_Stall(o_Stall),
        .o_StallCount(o_StallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Load-use rule: EX load writing a nonzero Rt that the real ID instruction reads.
    function automatic logic model_hz();
        logic rt_src;
        if (!STALL_EN) return 1'b0;
        rt_src = id.regdst | id.memwrite | id.branch;
        return ex_m.valid && ex_m.memread && id.valid && (ex_m.rt != 5'd0) &&
               ((ex_m.rt == id.rs) || (rt_src && (ex_m.rt == id.rt)));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ex_m  <= '0;
            cnt_m <= 16'd0;
        end else if (!en) begin
            ex_m  <= ex_m;
        end else if (flush) begin
            ex_m  <= '0;
        end else if (model_hz()) begin
            ex_m  <= '0;
            if (cnt_m != 16'hFFFF) cnt_m <= cnt_m + 16'd1;
        end else begin
            ex_m  <= id;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_valid", o_Valid, ex_m.valid);
            chk("m_ctrl", {o_RegDst, o_Jump, o_Branch, o_MemRead, o_MemToReg, o_MemWrite,
                           o_ALUSrc, o_RegWrite, o_ALUOp},
                          {ex_m.regdst, ex_m.jump, ex_m.branch, ex_m.memread, ex_m.memtoreg,
                           ex_m.memwrite, ex_m.alusrc, ex_m.regwrite, ex_m.aluop});
            chk("m_pc4", o_PC4, ex_m.pc4);
            chk("m_rd1", o_ReadData1, ex_m.rd1);
            chk("m_rd2", o_ReadData2, ex_m.rd2);
            chk("m_imm", o_Imm, ex_m.imm);
            chk("m_fields", {o_Rs, o_Rt, o_Rd, o_Funct}, {ex_m.rs, ex_m.rt, ex_m.rd, ex_m.funct});
            chk("m_stall", o_Stall, model_hz() & ~flush & ~rst);
            chk("m_count", o_StallCount, cnt_m);
        end
    end

    function automatic instr_t mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [31:0] a, input logic [31:0] b);
        instr_t x = '0;
        x.valid = 1'b1; x.regdst = 1'b1; x.aluop = 2'b10; x.regwrite = 1'b1;
        x.rs = rs; x.rt = rt; x.rd = rd; x.rd1 = a; x.rd2 = b; x.funct = 6'h20; x.pc4 = 32'h104;
        return x;
    endfunction

    function automatic instr_t mk_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        instr_t x = '0;
        x.valid = 1'b1; x.memread = 1'b1; x.memtoreg = 1'b1; x.alusrc = 1'b1; x.regwrite = 1'b1;
        x.rs = rs; x.rt = rt; x.imm = imm; x.pc4 = 32'h200;
        return x;
    endfunction

    function automatic instr_t mk_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        instr_t x = '0;
        x.valid = 1'b1; x.alusrc = 1'b1; x.regwrite = 1'b1;
        x.rs = rs; x.rt = rt; x.imm = imm; x.pc4 = 32'h300;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    instr_t tmp;

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b1; id = '1;

        // Reset with every input high for two edges.
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_valid", o_Valid, 0);
        chk("rst_aluop", o_ALUOp, 0);
        chk("rst_pc4", o_PC4, 0);
        chk("rst_count", o_StallCount, 0);
        chk("rst_stall", o_Stall, 0);

        // Pass-through of an ADD.
        rst = 1'b0; flush = 1'b0;
        id = mk_r(5'd1, 5'd2, 5'd3, 32'h5, 32'h7);
        tick();
        chk("add_aluop", o_ALUOp, 2'b10);
        chk("add_rd1", o_ReadData1, 32'h5);
        chk("add_rd2", o_ReadData2, 32'h7);
        chk("add_rd", o_Rd, 5'd3);
        chk("add_valid", o_Valid, 1);

        // Load-use: LW $8 then ADD using $8 as Rs.
        id = mk_lw(5'd2, 5'd8, 32'h4);
        tick();
        id = mk_r(5'd8, 5'd9, 5'd10, 32'h1, 32'h2);
        #1;
        chk("lu_stall", o_Stall, STALL_EN);
        tick();
        chk("lu_bubble_valid", o_Valid, !STALL_EN);
        chk("lu_bubble_memread", o_MemRead, 0);
        chk("lu_stall_clear", o_Stall, 0);
        chk("lu_count", o_StallCount, STALL_EN ? 1 : 0);
        tick();
        chk("lu_rs", o_Rs, 5'd8);
        chk("lu_valid", o_Valid, 1);

        // No false hazard: $zero destination, and ADDI whose Rt is a destination.
        id = mk_lw(5'd1, 5'd0, 32'h0);
        tick();
        id = mk_r(5'd0, 5'd0, 5'd4, 32'h0, 32'h0);
        #1;
        chk("zero_stall", o_Stall, 0);
        tick();
        id = mk_lw(5'd1, 5'd8, 32'h0);
        tick();
        id = mk_addi(5'd5, 5'd8, 32'h1);
        #1;
        chk("addi_stall", o_Stall, 0);
        tick();
        chk("addi_rt", o_Rt, 5'd8);
        chk("addi_alusrc", o_ALUSrc, 1);

        // Flush wins over a simultaneous hazard.
        id = mk_lw(5'd1, 5'd8, 32'h0);
        tick();
        id = mk_r(5'd8, 5'd1, 5'd2, 32'h3, 32'h4);
        flush = 1'b1;
        #1;
        chk("flush_stall", o_Stall, 0);
        tick();
        chk("flush_valid", o_Valid, 0);
        chk("flush_count", o_StallCount, STALL_EN ? 1 : 0);
        flush = 1'b0;
        tick();

        // Back-to-back dependent loads: each stalls once.
        id = mk_lw(5'd1, 5'd8, 32'h0);
        tick();
        id = mk_lw(5'd8, 5'd9, 32'h8);
        #1;
        chk("b2b_stall1", o_Stall, STALL_EN);
        tick();
        tick();
        id = mk_r(5'd9, 5'd1, 5'd2, 32'h0, 32'h0);
        #1;
        chk("b2b_stall2", o_Stall, STALL_EN);
        tick();
        tick();
        chk("b2b_count", o_StallCount, STALL_EN ? 3 : 0);

        // Enable low freezes state while inputs change; re-enable captures current inputs.
        id = mk_r(5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            id = mk_r(5'd4, 5'd5, 5'd6, 32'(i + 100), 32'(i + 200));
            tick();
        end
        chk("en_hold_rd1", o_ReadData1, 32'h11);
        chk("en_hold_rd", o_Rd, 5'd3);
        id = mk_r(5'd7, 5'd7, 5'd7, 32'h77, 32'h78);
        en = 1'b1;
        tick();
        chk("en_cap_rd1", o_ReadData1, 32'h77);
        chk("en_cap_rd", o_Rd, 5'd7);

        // Hazard while disabled: stall still reported, nothing moves, counter holds.
        id = mk_lw(5'd1, 5'd8, 32'h0);
        tick();
        id = mk_r(5'd8, 5'd2, 5'd3, 32'h0, 32'h0);
        en = 1'b0;
        #1;
        chk("dis_stall", o_Stall, STALL_EN);
        tick();
        chk("dis_count", o_StallCount, STALL_EN ? 3 : 0);
        chk("dis_memread", o_MemRead, 1);
        en = 1'b1;
        tick();
        chk("reen_count", o_StallCount, STALL_EN ? 4 : 0);
        tick();

        // Invalid ID instruction: no stall, o_Valid=0, controls still pass through.
        id = mk_lw(5'd1, 5'd8, 32'h0);
        tick();
        tmp = mk_r(5'd8, 5'd8, 5'd2, 32'h0, 32'h0);
        tmp.valid = 1'b0;
        id = tmp;
        #1;
        chk("inv_stall", o_Stall, 0);
        tick();
        chk("inv_valid", o_Valid, 0);
        chk("inv_regdst", o_RegDst, 1);
        chk("inv_aluop", o_ALUOp, 2'b10);

        // Reset in the middle of a stall discards it.
        id = mk_lw(5'd1, 5'd8, 32'h0);
        tick();
        id = mk_r(5'd8, 5'd2, 5'd3, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        chk("rstmid_stall", o_Stall, 0);
        tick();
        chk("rstmid_count", o_StallCount, 0);
        chk("rstmid_valid", o_Valid, 0);
        rst = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
